// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath mux selects and the packed control word produced by the decoder.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = 4'd0,
    S_DEC  = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10
  } pc_source_e;

  typedef enum logic [1:0] {
    ALUB_B       = 2'b00,
    ALUB_FOUR    = 2'b01,
    ALUB_IMM     = 2'b10,
    ALUB_IMM_SHL = 2'b11
  } alu_src_b_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    pc_source_e pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control decoder; fetch strobes are gated by
// mem_ready so the PC and IR only load on the cycle the fetch completes.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_e                state_i,
  input  logic                  mem_ready_i,
  input  logic [OPCODE_W-1:0]   opcode_i,
  output ctrl_t                 ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DEC: ctrl_o.alu_src_b = ALUB_IMM_SHL;
      S_MADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
      end
      S_MRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_REX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BR: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        ctrl_o.branch_ne     = (opcode_i == OP_BNE);
      end
      S_JMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
      end
      S_IEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
      end
      S_IWB: ctrl_o.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: state register, next-state logic and the
// PC write-enable combining unconditional and branch-conditional updates.
module mc_control
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [STATE_W-1:0]  state,
  output logic                illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    illegal = 1'b0;
    case (state_q)
      S_IF:  state_d = mem_ready ? S_DEC : S_IF;
      S_DEC: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MADR;
          OP_RTYPE:       state_d = S_REX;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:           state_d = S_JMP;
          OP_ADDI:        state_d = S_IEX;
          default: begin
            state_d = S_IF;
            illegal = 1'b1;
          end
        endcase
      end
      S_MADR: state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:  state_d = mem_ready ? S_MWB : S_MRD;
      S_MWR:  state_d = mem_ready ? S_IF : S_MWR;
      S_REX:  state_d = S_RWB;
      S_IEX:  state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .opcode_i    (opcode),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_source     = 2'(ctrl.pc_source);
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = 2'(ctrl.alu_src_b);
  assign alu_op        = 2'(ctrl.alu_op);
  assign state         = 4'(state_q);

  // Branch taken when zero disagrees with the bne polarity.
  assign pc_we = pc_write | (pc_write_cond & (zero ^ branch_ne));

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class through its
// state sequence and checks decoded controls at the falling edge.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_we, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source;
  logic       iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic       illegal;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_we         (pc_we),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .state         (state),
    .illegal       (illegal)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    step();
    check("rst_state", 8'(state), 8'd0);
    rst = 1'b0;
    #1;
    // First IF cycle after release
    check("if_state",    8'(state),    8'd0);
    check("if_mem_read", 8'(mem_read), 8'd1);
    check("if_ir_write", 8'(ir_write), 8'd1);
    check("if_pc_write", 8'(pc_write), 8'd1);
    check("if_pc_we",    8'(pc_we),    8'd1);
    check("if_alu_b",    8'(alu_src_b), 8'd1);

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    step(); check("lw_dec",  8'(state), 8'd1);
            check("lw_dec_alub", 8'(alu_src_b), 8'd3);
    step(); check("lw_madr", 8'(state), 8'd2);
            check("lw_madr_rw", 8'(reg_write), 8'd0);
    step(); check("lw_mrd",  8'(state), 8'd3);
            check("lw_mrd_iord", 8'(iord), 8'd1);
            check("lw_mrd_rw", 8'(reg_write), 8'd0);
    step(); check("lw_mwb",  8'(state), 8'd4);
            check("lw_mwb_rw",  8'(reg_write), 8'd1);
            check("lw_mwb_m2r", 8'(mem_to_reg), 8'd1);
    step(); check("lw_done", 8'(state), 8'd0);
            check("lw_done_rw", 8'(reg_write), 8'd0);

    // beq, zero=1: taken
    opcode = 6'b000100; zero = 1'b1;
    step(); check("beq_dec", 8'(state), 8'd1);
    step(); check("beq_br",  8'(state), 8'd8);
            check("beq_pc_we", 8'(pc_we), 8'd1);
            check("beq_pcsrc", 8'(pc_source), 8'd1);
            check("beq_bne",   8'(branch_ne), 8'd0);
    step(); check("beq_done", 8'(state), 8'd0);

    // bne, zero=1: not taken
    opcode = 6'b000101;
    step(); step();
    check("bne1_br",    8'(state), 8'd8);
    check("bne1_pc_we", 8'(pc_we), 8'd0);
    check("bne1_pcsrc", 8'(pc_source), 8'd1);
    check("bne1_bne",   8'(branch_ne), 8'd1);
    // bne, zero=0 in the same BR cycle: taken
    zero = 1'b0; #1;
    check("bne0_pc_we", 8'(pc_we), 8'd1);
    check("bne0_pcsrc", 8'(pc_source), 8'd1);
    step(); check("bne_done", 8'(state), 8'd0);

    // IF with memory stalled 3 cycles
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_state", 8'(state), 8'd0);
      check("stall_irw",   8'(ir_write), 8'd0);
      check("stall_pcw",   8'(pc_write), 8'd0);
      step();
    end
    mem_ready = 1'b1; #1;
    check("stall_end_state", 8'(state), 8'd0);
    check("stall_end_irw",   8'(ir_write), 8'd1);
    check("stall_end_pcw",   8'(pc_write), 8'd1);

    // illegal opcode
    opcode = 6'b111111;
    step(); check("ill_dec",   8'(state), 8'd1);
            check("ill_pulse", 8'(illegal), 8'd1);
            check("ill_rw",    8'(reg_write), 8'd0);
            check("ill_mw",    8'(mem_write), 8'd0);
            check("ill_pcwe",  8'(pc_we), 8'd0);
    step(); check("ill_done",  8'(state), 8'd0);
            check("ill_clear", 8'(illegal), 8'd0);

    // reset asserted mid-lw in MRD, with memory stalled
    opcode = 6'b100011;
    step(); step(); step();
    check("rst_mrd", 8'(state), 8'd3);
    rst = 1'b1; mem_ready = 1'b0;
    step(); check("rst_mid", 8'(state), 8'd0);
    rst = 1'b0; mem_ready = 1'b1;

    // sw: 0,1,2,5,0
    opcode = 6'b101011;
    step(); check("sw_dec",  8'(state), 8'd1);
    step(); check("sw_madr", 8'(state), 8'd2);
            check("sw_madr_mw", 8'(mem_write), 8'd0);
    step(); check("sw_mwr",  8'(state), 8'd5);
            check("sw_mwr_mw",   8'(mem_write), 8'd1);
            check("sw_mwr_iord", 8'(iord), 8'd1);
    step(); check("sw_done", 8'(state), 8'd0);
            check("sw_done_mw",   8'(mem_write), 8'd0);
            check("sw_done_iord", 8'(iord), 8'd0);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    step(); step();
    check("r_rex",    8'(state), 8'd6);
    check("r_aluop",  8'(alu_op), 8'd2);
    check("r_srca",   8'(alu_src_a), 8'd1);
    step(); check("r_rwb", 8'(state), 8'd7);
            check("r_dst", 8'(reg_dst), 8'd1);
            check("r_rw",  8'(reg_write), 8'd1);
    step(); check("r_done", 8'(state), 8'd0);

    // addi: 0,1,10,11,0
    opcode = 6'b001000;
    step(); step();
    check("addi_iex",  8'(state), 8'd10);
    check("addi_alub", 8'(alu_src_b), 8'd2);
    step(); check("addi_iwb", 8'(state), 8'd11);
            check("addi_rw",  8'(reg_write), 8'd1);
            check("addi_dst", 8'(reg_dst), 8'd0);
    step(); check("addi_done", 8'(state), 8'd0);

    // j: 0,1,9,0
    opcode = 6'b000010;
    step(); step();
    check("j_jmp",   8'(state), 8'd9);
    check("j_pcsrc", 8'(pc_source), 8'd2);
    check("j_pcwe",  8'(pc_we), 8'd1);
    step(); check("j_done", 8'(state), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It sits directly upstream of the program-counter register and drives its write-enable (`pc_we`), plus the mux selects and enables for the instruction register, memory, register file and ALU. The opcode arrives from the instruction register and `zero` from the ALU.

## Interface
- No parameters.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `opcode`  in  6  instruction[31:26], read from the instruction register
- `zero`  in  1  ALU zero flag, valid in the BR state
- `mem_ready`  in  1  memory completes the access this cycle
- `pc_we`  out  1  PC write enable: `pc_write | (pc_write_cond & (zero ^ branch_ne))`
- `pc_write`, `pc_write_cond`, `branch_ne`  out  1 each  PC-update terms
- `pc_source`  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target
- `iord`  out  1  memory address select: 0 PC, 1 ALUOut
- `mem_read`, `mem_write`, `ir_write`  out  1 each  memory and instruction-register strobes
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register-file controls
- `alu_src_a`  out  1  ALU A select: 0 PC, 1 register A
- `alu_src_b`  out  2  ALU B select: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- `alu_op`  out  2  00 add, 01 sub, 10 funct-decoded
- `state`  out  4  current state, for debug
- `illegal`  out  1  one-cycle pulse in DEC when the opcode is unsupported

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - bne 000101
  - j 000010
  - addi 001000
- States and encodings: IF=0, DEC=1, MADR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BR=8, JMP=9, IEX=10, IWB=11.
- Every output is Moore-decoded from `state`, except `pc_we` (combinational in `zero`) and the `mem_ready`-gated strobes.
- Outputs default to 0 in every state unless listed below.
- IF:
  - `mem_read`=1, `alu_src_b`=01.
  - `ir_write`=1 and `pc_write`=1 only when `mem_ready`=1.
  - Stays in IF while `mem_ready`=0.
- DEC:
  - `alu_src_b`=11 (branch target into ALUOut).
  - Next state by opcode: lw/sw→MADR, R→REX, beq/bne→BR, j→JMP, addi→IEX.
  - Any other opcode → IF with `illegal`=1.
- MADR: `alu_src_a`=1, `alu_src_b`=10. lw→MRD, sw→MWR.
- MRD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then →MWB.
- MWB: `reg_write`=1, `mem_to_reg`=1 →IF.
- MWR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then →IF.
- REX: `alu_src_a`=1, `alu_op`=10 →RWB.
- RWB: `reg_dst`=1, `reg_write`=1 →IF.
- BR: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `branch_ne`=(opcode==bne) →IF.
- JMP: `pc_write`=1, `pc_source`=10 →IF.
- IEX: `alu_src_a`=1, `alu_src_b`=10 →IWB.
- IWB: `reg_write`=1 →IF.
- Unreachable encodings 12–15 → IF next cycle, all outputs 0.
- `opcode` is sampled only in DEC, MADR and BR; the instruction register is stable there because `ir_write`=0.

## Timing
- Reset:
  - `rst` at a rising edge forces `state`=IF, overriding any transition, including mid-instruction.
  - While `rst` is held, outputs show IF decode; the PC register's own reset has priority, so `pc_write` is harmless.
- Cycles per instruction with zero wait states:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq/bne 3
  - j 3
  - illegal 2
- Each cycle with `mem_ready`=0 in IF, MRD or MWR adds one cycle. `pc_write`, `ir_write` and the state change are held off until the completing cycle.
- `pc_we` is valid before the rising edge that ends the state; the PC updates on that edge.

## Structure
- Package `mips_pkg`:
  - opcode constants
  - state enum, 4-bit
  - `alu_op` and `pc_source` encodings
- Sub-module `mc_ctrl_decode`: combinational state→control decoder.
- `mc_control` holds the state register, next-state logic and `pc_we`.

## Test plan
- `rst`=1 for 2 cycles, then release with `mem_ready`=1: `state`=0, `mem_read`=1, `ir_write`=1, `pc_write`=1, `pc_we`=1 in the first cycle.
- lw (100011), `mem_ready`=1: states 0,1,2,3,4,0. `reg_write`=1 with `mem_to_reg`=1 only in state 4.
- beq with `zero`=1 → `pc_we`=1 in BR. bne with `zero`=1 → `pc_we`=0. bne with `zero`=0 → `pc_we`=1. `pc_source`=01 in all three cases.
- IF with `mem_ready` low for 3 cycles: `state` stays 0, and `ir_write`=`pc_write`=0 for 3 cycles, then 1 in the fourth.
- Opcode 111111 → `illegal` pulses in DEC and `state` returns to 0 with no writes. `rst` asserted in MRD → `state`=0 next edge.
- sw (101011) → states 0,1,2,5,0. `mem_write`=1 and `iord`=1 in state 5 only.
